// File: rtl/led_matrix_scan_driver_if.sv
// Host-side bus of the LED matrix scan driver: row writes into the back bank,
// bank-swap request and per-colour brightness, plus swap/frame status back to the host.
interface led_matrix_scan_driver_if #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int COLORS   = 2,
    parameter int BRIGHT_W = 5
);
    logic                                           wr_en;
    logic [$clog2(ROWS)-1:0]                        wr_row;
    logic [((COLORS > 1) ? $clog2(COLORS) : 1)-1:0] wr_color;
    logic [COLS-1:0]                                wr_data;
    logic                                           swap_req;
    logic [COLORS*BRIGHT_W-1:0]                     bright;
    logic                                           swap_pending;
    logic                                           frame_done;

    modport master (
        output wr_en, wr_row, wr_color, wr_data, swap_req, bright,
        input  swap_pending, frame_done
    );

    modport slave (
        input  wr_en, wr_row, wr_color, wr_data, swap_req, bright,
        output swap_pending, frame_done
    );
endinterface

// File: rtl/led_matrix_scan_driver.sv
// Scan engine for bicolour LED matrix Pmods: double-buffered frame store, serial column
// shift-out, storage latch and PWM-dimmed colour enable for every (row, colour) slot.
module led_matrix_scan_driver #(
    parameter int CLK_DIV     = 1350,
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int COLORS      = 2,
    parameter int DWELL_TICKS = 16,
    parameter int BRIGHT_W    = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    led_matrix_scan_driver_if.slave host,
    output logic                    ser_data,
    output logic                    ser_clk,
    output logic                    ser_latch,
    output logic [$clog2(ROWS)-1:0] row_addr,
    output logic [COLORS-1:0]       col_en_n,
    output logic                    clr_n
);
    localparam int ROW_W      = $clog2(ROWS);
    localparam int COLOR_W    = (COLORS > 1) ? $clog2(COLORS) : 1;
    localparam int SLOTS      = ROWS * COLORS;
    localparam int WORDS      = 2 * SLOTS;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int STEP_W     = $clog2(2 * COLS + DWELL_TICKS + 1);
    localparam int SHIFT_LAST = 2 * COLS - 1;
    localparam int DWELL_LAST = DWELL_TICKS - 1;

    typedef enum logic [1:0] {ST_SHIFT, ST_LATCH, ST_DWELL} state_t;

    state_t              state_reg;
    logic [STEP_W-1:0]   step_reg;
    logic [ROW_W-1:0]    row_reg;
    logic [COLOR_W-1:0]  color_reg;
    logic                front_reg;
    logic                swap_pending_reg;
    logic                frame_done_reg;
    logic [STEP_W-1:0]   bright_reg;
    logic                ser_data_reg;
    logic                ser_clk_reg;
    logic                ser_latch_reg;
    logic [ROW_W-1:0]    row_addr_reg;
    logic [COLORS-1:0]   col_en_n_reg;
    logic                clr_n_reg;
    logic [DIV_W-1:0]    div_reg;

    logic                tick;
    logic                wr_ok;
    int                  wr_idx;
    int                  rd_idx;
    int                  nxt_bit;
    logic                slot_last;
    logic                dwell_last;
    logic                frame_end;
    logic                swap_now;
    logic [ROW_W-1:0]    nxt_row;
    logic [COLOR_W-1:0]  nxt_color;
    logic [COLS-1:0]     rd_word;
    logic                nxt_data;
    logic [BRIGHT_W-1:0] bright_sel;
    logic [STEP_W-1:0]   bright_clamp;
    logic [COLORS-1:0]   en_mask;
    logic [COLS-1:0]     bank_word [WORDS];

    assign tick = (div_reg == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_reg <= '0;
        else if (tick) div_reg <= '0;
        else           div_reg <= div_reg + 1'b1;
    end

    // Word index = bank*SLOTS + row*COLORS + colour; the host always writes the bank not scanned.
    always_comb begin
        wr_ok  = host.wr_en && (int'(host.wr_row) < ROWS) && (int'(host.wr_color) < COLORS);
        wr_idx = (front_reg ? 0 : SLOTS) + int'(host.wr_row) * COLORS + int'(host.wr_color);
    end

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            logic [COLS-1:0] word_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                        word_reg <= '0;
                else if (wr_ok && (wr_idx == gi)) word_reg <= host.wr_data;
            end
            assign bank_word[gi] = word_reg;
        end
    endgenerate

    always_comb begin
        slot_last  = (int'(row_reg) == ROWS - 1) && (int'(color_reg) == COLORS - 1);
        dwell_last = (state_reg == ST_DWELL) && (int'(step_reg) == DWELL_LAST);
        frame_end  = tick && dwell_last && slot_last;
        swap_now   = frame_end && swap_pending_reg;

        nxt_row   = row_reg;
        nxt_color = color_reg;
        nxt_bit   = COLS - 1 - (int'(step_reg) + 1) / 2;
        if (dwell_last) begin
            nxt_bit = COLS - 1;
            if (int'(color_reg) == COLORS - 1) begin
                nxt_color = '0;
                nxt_row   = (int'(row_reg) == ROWS - 1) ? '0 : row_reg + 1'b1;
            end else begin
                nxt_color = color_reg + 1'b1;
            end
        end

        // A write landing on the swap clock goes into the bank that becomes front, so forward it.
        rd_idx  = ((front_reg ^ swap_now) ? SLOTS : 0) + int'(nxt_row) * COLORS + int'(nxt_color);
        rd_word = '0;
        for (int w = 0; w < WORDS; w++)
            if (w == rd_idx) rd_word = bank_word[w];
        if (wr_ok && (wr_idx == rd_idx)) rd_word = host.wr_data;

        nxt_data = 1'b0;
        for (int c = 0; c < COLS; c++)
            if (c == nxt_bit) nxt_data = rd_word[c];

        bright_sel = '0;
        for (int k = 0; k < COLORS; k++)
            if (k == int'(color_reg)) bright_sel = host.bright[k*BRIGHT_W +: BRIGHT_W];
        bright_clamp = (int'(bright_sel) > DWELL_TICKS) ? STEP_W'(DWELL_TICKS) : STEP_W'(bright_sel);

        en_mask = ~(COLORS'(1) << color_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_SHIFT;
            step_reg         <= '0;
            row_reg          <= '0;
            color_reg        <= '0;
            front_reg        <= 1'b0;
            swap_pending_reg <= 1'b0;
            frame_done_reg   <= 1'b0;
            bright_reg       <= '0;
            ser_data_reg     <= 1'b0;
            ser_clk_reg      <= 1'b0;
            ser_latch_reg    <= 1'b0;
            row_addr_reg     <= '0;
            col_en_n_reg     <= '1;
            clr_n_reg        <= 1'b0;
        end else begin
            frame_done_reg <= frame_end;
            if (swap_now) begin
                front_reg        <= ~front_reg;
                swap_pending_reg <= host.swap_req;
            end else if (host.swap_req) begin
                swap_pending_reg <= 1'b1;
            end

            if (tick) begin
                clr_n_reg <= 1'b1;
                case (state_reg)
                    ST_SHIFT: begin
                        if (int'(step_reg) == SHIFT_LAST) begin
                            state_reg     <= ST_LATCH;
                            step_reg      <= '0;
                            ser_clk_reg   <= 1'b0;
                            ser_latch_reg <= 1'b1;
                            row_addr_reg  <= row_reg;
                            bright_reg    <= bright_clamp;
                        end else begin
                            step_reg    <= step_reg + 1'b1;
                            ser_clk_reg <= ~step_reg[0];
                            if (step_reg[0]) ser_data_reg <= nxt_data;
                        end
                    end
                    ST_LATCH: begin
                        state_reg     <= ST_DWELL;
                        step_reg      <= '0;
                        ser_latch_reg <= 1'b0;
                        col_en_n_reg  <= (bright_reg != '0) ? en_mask : '1;
                    end
                    ST_DWELL: begin
                        if (dwell_last) begin
                            state_reg    <= ST_SHIFT;
                            step_reg     <= '0;
                            row_reg      <= nxt_row;
                            color_reg    <= nxt_color;
                            col_en_n_reg <= '1;
                            ser_clk_reg  <= 1'b0;
                            ser_data_reg <= nxt_data;
                        end else begin
                            step_reg     <= step_reg + 1'b1;
                            col_en_n_reg <= ((int'(step_reg) + 1) < int'(bright_reg)) ? en_mask : '1;
                        end
                    end
                    default: state_reg <= ST_SHIFT;
                endcase
            end
        end
    end

    assign ser_data          = ser_data_reg;
    assign ser_clk           = ser_clk_reg;
    assign ser_latch         = ser_latch_reg;
    assign row_addr          = row_addr_reg;
    assign col_en_n          = col_en_n_reg;
    assign clr_n             = clr_n_reg;
    assign host.swap_pending = swap_pending_reg;
    assign host.frame_done   = frame_done_reg;
endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Directed bench for led_matrix_scan_driver: decodes the serial pins back into latched row
// patterns and per-slot enable on-times, and compares them with hand-computed values.
module tb_led_matrix_scan_driver;
    localparam int CLK_DIV  = 2;
    localparam int ROWS     = 8;
    localparam int COLS     = 8;
    localparam int COLORS   = 2;
    localparam int DWELL    = 16;
    localparam int BRIGHT_W = 5;
    localparam int SLOTS    = 16;
    // 16 slots * (16 shift + 1 latch + 16 dwell) ticks * 2 clk per tick
    localparam int FRAME_CLKS = 1056;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_data, ser_clk, ser_latch, clr_n;
    logic [2:0] row_addr;
    logic [1:0] col_en_n;

    led_matrix_scan_driver_if #(.ROWS(ROWS), .COLS(COLS), .COLORS(COLORS), .BRIGHT_W(BRIGHT_W)) host();

    led_matrix_scan_driver #(
        .CLK_DIV(CLK_DIV), .ROWS(ROWS), .COLS(COLS), .COLORS(COLORS),
        .DWELL_TICKS(DWELL), .BRIGHT_W(BRIGHT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .host(host),
        .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch),
        .row_addr(row_addr), .col_en_n(col_en_n), .clr_n(clr_n)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_mis = 0;
    int         cyc_cnt;
    logic       prev_sclk, prev_latch;
    logic [7:0] shift_acc;
    int         slot_idx, rises, latch_total, en_low_total;
    int         low_cnt [2];
    logic [7:0] lat_pat [SLOTS];
    int         lat_row [SLOTS];
    int         lat_rises [SLOTS];
    int         dwell_low [SLOTS][2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock step; decodes the pins exactly as the shift/storage register would.
    task automatic cyc();
        int prv;
        @(posedge clk); #1;
        cyc_cnt++;
        if (ser_clk && !prev_sclk) begin
            shift_acc = {shift_acc[6:0], ser_data};
            rises++;
        end
        if (ser_latch && !prev_latch) begin
            prv = (slot_idx + SLOTS - 1) % SLOTS;
            dwell_low[prv][0] = low_cnt[0];
            dwell_low[prv][1] = low_cnt[1];
            low_cnt[0] = 0;
            low_cnt[1] = 0;
            lat_pat[slot_idx]   = shift_acc;
            lat_row[slot_idx]   = int'(row_addr);
            lat_rises[slot_idx] = rises;
            rises = 0;
            latch_total++;
            slot_idx = (slot_idx + 1) % SLOTS;
        end
        for (int k = 0; k < 2; k++)
            if (!col_en_n[k]) begin
                low_cnt[k]++;
                en_low_total++;
            end
        prev_sclk  = ser_clk;
        prev_latch = ser_latch;
    endtask

    task automatic release_reset();
        shift_acc = '0; slot_idx = 0; rises = 0; latch_total = 0; en_low_total = 0;
        low_cnt[0] = 0; low_cnt[1] = 0; prev_sclk = 1'b0; prev_latch = 1'b0;
        for (int s = 0; s < SLOTS; s++) begin
            lat_pat[s] = '0; lat_row[s] = 0; lat_rises[s] = 0;
            dwell_low[s][0] = 0; dwell_low[s][1] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        cyc_cnt = 0;
        $display("reset released");
    endtask

    task automatic wait_fd(input string tag);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!host.frame_done && n < 3000);
        if (!host.frame_done) chk({tag, "_timeout"}, host.frame_done, 1);
        $display("frame_done (%s) at cycle %0d", tag, cyc_cnt);
    endtask

    task automatic host_write(input int r, input int c, input logic [7:0] d);
        host.wr_en = 1'b1; host.wr_row = 3'(r); host.wr_color = 1'(c); host.wr_data = d;
        cyc();
        host.wr_en = 1'b0;
        $display("write row %0d colour %0d data 0x%02h", r, c, d);
    endtask

    task automatic pulse_swap();
        host.swap_req = 1'b1;
        cyc();
        host.swap_req = 1'b0;
        $display("swap_req pulsed");
    endtask

    initial begin
        int bad;
        int n;
        host.wr_en = 1'b0; host.wr_row = '0; host.wr_color = '0; host.wr_data = '0;
        host.swap_req = 1'b0; host.bright = '0;
        release_reset();

        // Reset state, then blank first frame with bright=0
        chk("rst_clr_n", clr_n, 0);
        chk("rst_col_en_n", col_en_n, 2'b11);
        chk("rst_ser_latch", ser_latch, 0);
        chk("rst_ser_clk", ser_clk, 0);
        chk("rst_row_addr", row_addr, 0);
        chk("rst_swap_pending", host.swap_pending, 0);
        chk("rst_frame_done", host.frame_done, 0);
        while (!clr_n && cyc_cnt < 10) cyc();
        chk("clr_n_low_clks", cyc_cnt, CLK_DIV);
        wait_fd("f1");
        chk("first_frame_clks", cyc_cnt, FRAME_CLKS);
        chk("blank_en_low", en_low_total, 0);
        chk("latches_per_frame", latch_total, SLOTS);
        bad = 0;
        for (int s = 0; s < SLOTS; s++) if (lat_row[s] != s / 2) bad++;
        chk("row_order_bad", bad, 0);
        cyc_cnt = 0;
        wait_fd("f2");
        chk("frame_period_clks", cyc_cnt, FRAME_CLKS);

        // Row 3 red = A5 then swap; bright red=5 green=0
        host.bright = {5'd0, 5'd5};
        host_write(3, 0, 8'hA5);
        pulse_swap();
        chk("swap_pending_set", host.swap_pending, 1);
        wait_fd("f3");
        chk("pre_swap_pat", lat_pat[6], 8'h00);
        chk("swap_pending_clr", host.swap_pending, 0);
        wait_fd("f4");
        chk("pat_r3_red", lat_pat[6], 8'hA5);
        chk("pat_r3_green", lat_pat[7], 8'h00);
        chk("rises_slot6", lat_rises[6], 8);
        chk("row_slot6", lat_row[6], 3);
        chk("red_on_clks", dwell_low[0][0], 10);
        chk("red_slot_green", dwell_low[0][1], 0);
        chk("green_slot_off", dwell_low[1][1], 0);
        chk("r3_red_on_clks", dwell_low[6][0], 10);

        host.bright = {5'd0, 5'd31};
        wait_fd("f5");
        chk("red_clamped_clks", dwell_low[2][0], 2 * DWELL);
        chk("green_still_off", dwell_low[3][1], 0);

        // Write without swap: front must not change
        host.bright = {5'd0, 5'd5};
        host_write(3, 0, 8'h3C);
        for (int f = 0; f < 3; f++) begin
            wait_fd("hold");
            chk("held_pat", lat_pat[6], 8'hA5);
        end
        repeat (300) cyc();
        pulse_swap();
        chk("mid_pending", host.swap_pending, 1);
        wait_fd("f9");
        chk("mid_frame_pat", lat_pat[6], 8'hA5);
        chk("mid_pending_clr", host.swap_pending, 0);
        wait_fd("f10");
        chk("swapped_pat", lat_pat[6], 8'h3C);

        // Write and swap_req on the frame-end clock
        for (int i = 0; i < FRAME_CLKS - 1; i++) begin
            cyc();
            if (i == 100) host.swap_req = 1'b1;
            if (i == 101) host.swap_req = 1'b0;
            if (i == 200) chk("fe_pending_pre", host.swap_pending, 1);
        end
        host.wr_en = 1'b1; host.wr_row = 3'd7; host.wr_color = 1'b1; host.wr_data = 8'h81;
        host.swap_req = 1'b1;
        cyc();
        host.wr_en = 1'b0; host.swap_req = 1'b0;
        $display("write row 7 colour 1 data 0x81 with swap_req on frame-end clock");
        chk("fe_frame_done", host.frame_done, 1);
        chk("fe_rearmed", host.swap_pending, 1);
        wait_fd("f12");
        chk("fe_new_pat", lat_pat[15], 8'h81);
        chk("fe_other_pat", lat_pat[6], 8'hA5);
        chk("fe_rearm_done", host.swap_pending, 0);
        wait_fd("f13");
        chk("rearm_pat15", lat_pat[15], 8'h00);
        chk("rearm_pat6", lat_pat[6], 8'h3C);

        // Asynchronous reset during DWELL of slot (4,1)
        host.bright = {5'd20, 5'd5};
        n = 0;
        do begin
            cyc();
            n++;
        end while (!(ser_latch && slot_idx == 10) && n < 3000);
        if (n >= 3000) chk("wait_slot9_timeout", ser_latch, 1);
        repeat (4) cyc();
        chk("dwell_green_on", col_en_n, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        $display("reset asserted during dwell");
        chk("async_col_en_n", col_en_n, 2'b11);
        chk("async_ser_latch", ser_latch, 0);
        chk("async_row_addr", row_addr, 0);
        chk("async_clr_n", clr_n, 0);
        release_reset();
        wait_fd("post_rst");
        chk("post_rst_frame_clks", cyc_cnt, FRAME_CLKS);
        chk("post_rst_latches", latch_total, SLOTS);
        chk("post_rst_first_row", lat_row[0], 0);
        bad = 0;
        for (int s = 0; s < SLOTS; s++) if (lat_pat[s] != 8'h00) bad++;
        chk("post_rst_blank_bad", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
